dmem_responder: RTL

Data-memory responder for the pipelined MIPS core's memory-stage port. Accepts one load or store per request from the core's M stage, inserts a parameterised number of wait states while holding the pipeline with a stall, performs byte/half/word access with MIPS lane selection and extension, and flags misaligned addresses. It is the slave end of the core's data interface and replaces the zero-latency ideal data RAM.

---
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS M stage: multi-cycle load/store with wait states,
// byte/half/word lane selection, load extension and misalignment flags.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreqM,
  input  logic        memwriteM,
  input  logic [1:0]  sizeM,
  input  logic        unsignedM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallmem,
  output logic        adelM,
  output logic        adesM
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, uns_q;
  logic [1:0]          size_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         readdata_q;

  logic                is_idle, misaligned, aligned_req, access;
  logic                acc_we, acc_uns;
  logic [1:0]          acc_size, acc_lane;
  logic [ADDR_WIDTH+1:0] acc_addr;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]         acc_wdata, wr_data, rd_word, rd_shift, load_val;
  logic [3:0]          byte_en;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;

  // Address bits above the RAM are ignored, so the memory aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addrM[31:ADDR_WIDTH+2];

  assign is_idle = (state_q == S_IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (sizeM)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addrM[0];
      default: misaligned = |addrM[1:0];
    endcase
  end

  assign aligned_req = memreqM & ~misaligned;
  assign adelM = is_idle & memreqM & misaligned & ~memwriteM;
  assign adesM = is_idle & memreqM & misaligned & memwriteM;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stallmem = 1'b0;
    access   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aligned_req) begin
          stallmem = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stallmem = 1'b1;
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (is_idle && aligned_req) begin
        we_q    <= memwriteM;
        uns_q   <= unsignedM;
        size_q  <= sizeM;
        addr_q  <= addrM[ADDR_WIDTH+1:0];
        wdata_q <= writedataM;
      end
    end
  end

  // With zero wait states the access happens on the accepting edge, so use the live inputs.
  assign acc_we    = is_idle ? memwriteM : we_q;
  assign acc_uns   = is_idle ? unsignedM : uns_q;
  assign acc_size  = is_idle ? sizeM : size_q;
  assign acc_addr  = is_idle ? addrM[ADDR_WIDTH+1:0] : addr_q;
  assign acc_wdata = is_idle ? writedataM : wdata_q;
  assign acc_idx   = acc_addr[ADDR_WIDTH+1:2];
  assign acc_lane  = acc_addr[1:0];

  always_comb begin
    byte_en = 4'b1111;
    wr_data = acc_wdata;
    case (acc_size)
      2'b00: begin
        byte_en = 4'b0001 << acc_lane;
        wr_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        byte_en = acc_lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_data = acc_wdata;
      end
    endcase
  end

  // One byte-wide RAM per lane so each lane has its own write enable.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (access && acc_we && byte_en[gi])
          mem[acc_idx] <= wr_data[gi*8 +: 8];
      end
      assign rd_word[gi*8 +: 8] = mem[acc_idx];
    end
  endgenerate

  assign rd_shift = rd_word >> {acc_lane, 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = acc_lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = rd_word;
    case (acc_size)
      2'b00:   load_val = acc_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_val = acc_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      readdata_q <= 32'h0;
    else if (access && !acc_we)
      readdata_q <= load_val;
  end

  assign readdataM = readdata_q;

endmodule
